// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: text segment base, bubble word and the
// next-PC select encoding used by the fetch, control and hazard units.
package mips_pkg;

    localparam int          DATA_WIDTH = 32;
    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_PC4 = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/instruction_fetch_unit_ifid_register.sv
// Generic stall/flush pipeline register carrying an instruction word, its
// PC+4 and a valid bit. A bubble request beats a hold request.
module ifid_register
    import mips_pkg::*;
#(
    parameter int          W        = DATA_WIDTH,
    parameter logic [W-1:0] BUBBLE_WORD = NOP_WORD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Bubble_i,
    input  logic         Hold_i,
    input  logic [W-1:0] Instruction_i,
    input  logic [W-1:0] PC_Plus_4_i,
    output logic [W-1:0] Instruction_o,
    output logic [W-1:0] PC_Plus_4_o,
    output logic         Valid_o
);

    always_ff @(posedge clk) begin
        if (reset || Bubble_i) begin
            Instruction_o <= BUBBLE_WORD;
            PC_Plus_4_o   <= '0;
            Valid_o       <= 1'b0;
        end else if (!Hold_i) begin
            Instruction_o <= Instruction_i;
            PC_Plus_4_o   <= PC_Plus_4_i;
            Valid_o       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: program counter, next-PC redirect mux, out-of-window fetch
// fault detection and the IF/ID pipeline register.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int                    DATA_WIDTH   = mips_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = mips_pkg::TEXT_BASE,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = mips_pkg::NOP_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    input  logic                  Branch_Taken_i,
    input  logic [DATA_WIDTH-1:0] Branch_Target_i,
    input  logic                  Jump_i,
    input  logic [25:0]           Jump_Target_i,
    input  logic                  Jump_Register_i,
    input  logic [DATA_WIDTH-1:0] Register_Target_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
    output logic [DATA_WIDTH-1:0] IFID_PC_Plus_4_o,
    output logic                  IFID_Valid_o,
    output logic                  Fetch_Error_o
);

    // Window end kept in one extra bit so a base near the top of memory cannot wrap.
    localparam logic [DATA_WIDTH:0] WIN_END =
        {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_plus4;
    logic                  err_q, err_d;
    logic                  fault, freeze;
    pc_sel_e               sel;

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);
    assign fault    = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_BASE) ||
                      ({1'b0, pc_q} >= WIN_END);
    // A stalled fetch is not consumed, so its fault is deferred until release.
    assign err_d    = err_q || (fault && !Stall_i);
    assign freeze   = err_d;

    always_comb begin
        sel = SEL_PC4;
        if (Jump_Register_i)     sel = SEL_JR;
        else if (Jump_i)         sel = SEL_J;
        else if (Branch_Taken_i) sel = SEL_BR;
    end

    always_comb begin
        pc_d = pc_q;
        if (!freeze) begin
            unique case (sel)
                SEL_JR:  pc_d = Register_Target_i;
                SEL_J:   pc_d = {pc_plus4[DATA_WIDTH-1:28], Jump_Target_i, 2'b00};
                SEL_BR:  pc_d = Branch_Target_i;
                default: pc_d = Stall_i ? pc_q : pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= TEXT_BASE;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    ifid_register #(
        .W           (DATA_WIDTH),
        .BUBBLE_WORD (NOP_WORD)
    ) u_ifid (
        .clk           (clk),
        .reset         (reset),
        .Bubble_i      (err_q || Flush_i || (fault && !Stall_i)),
        .Hold_i        (Stall_i),
        .Instruction_i (Instruction_i),
        .PC_Plus_4_i   (pc_plus4),
        .Instruction_o (IFID_Instruction_o),
        .PC_Plus_4_o   (IFID_PC_Plus_4_o),
        .Valid_o       (IFID_Valid_o)
    );

    assign PC_o          = pc_q;
    assign Fetch_Error_o = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small ROM model and an
// expectation queue popped one cycle after each step is driven.
module tb_instruction_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall_i, Flush_i, Branch_Taken_i, Jump_i, Jump_Register_i;
    logic [31:0] Branch_Target_i, Register_Target_i, Instruction_i;
    logic [25:0] Jump_Target_i;
    logic [31:0] PC_o, IFID_Instruction_o, IFID_PC_Plus_4_o;
    logic        IFID_Valid_o, Fetch_Error_o;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] pc);
        logic [31:0] idx;
        idx = (pc - BASE) >> 2;
        case (idx)
            32'd0:   rom = 32'h2008_0005;
            32'd1:   rom = 32'h2009_0003;
            32'd2:   rom = 32'h0109_5020;
            default: rom = {16'hC0DE, pc[15:0]};
        endcase
    endfunction

    assign Instruction_i = rom(PC_o);

    instruction_fetch_unit dut (
        .clk                (clk),
        .reset              (reset),
        .Stall_i            (Stall_i),
        .Flush_i            (Flush_i),
        .Branch_Taken_i     (Branch_Taken_i),
        .Branch_Target_i    (Branch_Target_i),
        .Jump_i             (Jump_i),
        .Jump_Target_i      (Jump_Target_i),
        .Jump_Register_i    (Jump_Register_i),
        .Register_Target_i  (Register_Target_i),
        .Instruction_i      (Instruction_i),
        .PC_o               (PC_o),
        .IFID_Instruction_o (IFID_Instruction_o),
        .IFID_PC_Plus_4_o   (IFID_PC_Plus_4_o),
        .IFID_Valid_o       (IFID_Valid_o),
        .Fetch_Error_o      (Fetch_Error_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue what the DUT must show after the next edge, then take the edge and compare.
    task automatic cyc(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic valid, input logic err);
        exp_t e;
        sb.push_back('{pc, instr, pc4, valid, err});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"},    PC_o,               e.pc);
        chk({tag, ".instr"}, IFID_Instruction_o, e.instr);
        chk({tag, ".pc4"},   IFID_PC_Plus_4_o,   e.pc4);
        chk({tag, ".valid"}, {31'd0, IFID_Valid_o},  {31'd0, e.valid});
        chk({tag, ".err"},   {31'd0, Fetch_Error_o}, {31'd0, e.err});
    endtask

    task automatic idle();
        Stall_i = 0; Flush_i = 0; Branch_Taken_i = 0; Jump_i = 0; Jump_Register_i = 0;
    endtask

    initial begin
        reset = 1; idle();
        Branch_Target_i = 0; Register_Target_i = 0; Jump_Target_i = 0;
        cyc("reset", BASE, 32'h0, 32'h0, 0, 0);
        reset = 0;

        cyc("run0", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 0);
        cyc("run1", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 0);

        Stall_i = 1;
        cyc("stall0", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 0);
        cyc("stall1", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 0);
        Stall_i = 0;
        cyc("release", 32'h0040_000C, 32'h0109_5020, 32'h0040_000C, 1, 0);

        Stall_i = 1; Flush_i = 1; Branch_Taken_i = 1; Branch_Target_i = 32'h0040_0020;
        cyc("br_flush_stall", 32'h0040_0020, 32'h0, 32'h0, 0, 0);
        idle();
        cyc("after_br", 32'h0040_0024, rom(32'h0040_0020), 32'h0040_0024, 1, 0);

        Jump_i = 1; Jump_Register_i = 1;
        Register_Target_i = 32'h0040_0040; Jump_Target_i = 26'h010_0004;
        cyc("jr_wins", 32'h0040_0040, rom(32'h0040_0024), 32'h0040_0028, 1, 0);
        Jump_Register_i = 0;
        cyc("jump", 32'h0040_0010, rom(32'h0040_0040), 32'h0040_0044, 1, 0);
        idle();
        cyc("after_j", 32'h0040_0014, rom(32'h0040_0010), 32'h0040_0014, 1, 0);

        Jump_Register_i = 1; Register_Target_i = 32'h0040_0102;
        cyc("jr_misalign", 32'h0040_0102, rom(32'h0040_0014), 32'h0040_0018, 1, 0);
        idle();
        cyc("fault", 32'h0040_0102, 32'h0, 32'h0, 0, 1);
        Branch_Taken_i = 1; Branch_Target_i = 32'h0040_0020; Stall_i = 1;
        cyc("frozen", 32'h0040_0102, 32'h0, 32'h0, 0, 1);
        reset = 1;
        cyc("reset_err", BASE, 32'h0, 32'h0, 0, 0);
        reset = 0; idle();

        for (int i = 0; i < 64; i++)
            cyc("walk", BASE + 32'(4 * (i + 1)), rom(BASE + 32'(4 * i)), BASE + 32'(4 * (i + 1)), 1, 0);

        Stall_i = 1;
        cyc("end_stall0", 32'h0040_0100, rom(32'h0040_00FC), 32'h0040_0100, 1, 0);
        cyc("end_stall1", 32'h0040_0100, rom(32'h0040_00FC), 32'h0040_0100, 1, 0);
        Stall_i = 0;
        cyc("end_fault", 32'h0040_0100, 32'h0, 32'h0, 0, 1);
        Flush_i = 1;
        cyc("end_hold", 32'h0040_0100, 32'h0, 32'h0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
